// File: rtl/lut_sweep_pkg.sv
// Shared definitions for the LUT sweep checker: FSM encodings and sweep length.
`ifndef LUT_SWEEP_LEN
`define LUT_SWEEP_LEN(n) (1 << (n))
`endif

package lut_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Number of input vectors swept for an n-input function.
  function automatic int sweep_len(input int n);
    return `LUT_SWEEP_LEN(n);
  endfunction

endpackage

// File: rtl/lut_sweep_checker_cell.sv
// Single-bit read of a programmable truth table at an input vector index.
module lut_cell #(
  parameter int N_IN = 4
) (
  input  logic [(1 << N_IN)-1:0] lut,
  input  logic [N_IN-1:0]        idx,
  output logic                   bit_out
);

  // The index spans exactly the table depth, so every read is in range.
  assign bit_out = lut[idx];

endmodule

// File: rtl/lut_sweep_checker.sv
// Sweeps every input vector of two captured truth tables and compares them,
// reporting equivalence, mismatch count and the lowest failing vector.
module lut_sweep_checker
  import lut_sweep_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop_first,
  input  logic [sweep_len(N_IN)-1:0] lut_a,
  input  logic [sweep_len(N_IN)-1:0] lut_b,
  output logic                       busy,
  output logic                       done,
  output logic                       equal,
  output logic [N_IN:0]              mismatch_count,
  output logic [N_IN-1:0]            first_mismatch,
  output logic [N_IN-1:0]            cur_vec,
  output logic                       s_a,
  output logic                       s_b
);

  localparam int LEN = sweep_len(N_IN);
  localparam int CW  = N_IN + 1;

  state_t           state;
  state_t           state_next;
  logic [LEN-1:0]   lut_a_q;
  logic [LEN-1:0]   lut_b_q;
  logic             stop_first_q;
  logic             mism;
  logic             last_vec;
  logic             sweep_end;
  logic             start_accept;

  lut_cell #(.N_IN(N_IN)) u_cell_a (
    .lut     (lut_a_q),
    .idx     (cur_vec),
    .bit_out (s_a)
  );

  lut_cell #(.N_IN(N_IN)) u_cell_b (
    .lut     (lut_b_q),
    .idx     (cur_vec),
    .bit_out (s_b)
  );

  assign mism         = s_a ^ s_b;
  assign last_vec     = &cur_vec;
  assign sweep_end    = (state == S_SWEEP) && (last_vec || (stop_first_q && mism));
  assign start_accept = start && ((state == S_IDLE) || (state == S_DONE));

  // Next-state selection: start is honoured only outside a sweep.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      S_IDLE,
      S_DONE:  if (start_accept) state_next = S_SWEEP;
      S_SWEEP: if (sweep_end)    state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Capture, vector counter and result registers.
  always_ff @(posedge clk) begin
    // NOTE: the captured truth tables are reset too, so s_a/s_b read 0 after
    // reset instead of exposing a stale function.
    if (!rst_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      equal          <= 1'b0;
      mismatch_count <= '0;
      first_mismatch <= '0;
      cur_vec        <= '0;
      lut_a_q        <= '0;
      lut_b_q        <= '0;
      stop_first_q   <= 1'b0;
    end else begin
      busy <= (state_next == S_SWEEP);
      if (start_accept) begin
        lut_a_q        <= lut_a;
        lut_b_q        <= lut_b;
        stop_first_q   <= stop_first;
        cur_vec        <= '0;
        mismatch_count <= '0;
        first_mismatch <= '0;
        done           <= 1'b0;
        equal          <= 1'b0;
      end else if (state == S_SWEEP) begin
        if (mism) begin
          // A full sweep counts at most LEN mismatches, which fits in CW bits.
          mismatch_count <= mismatch_count + CW'(1);
          if (mismatch_count == '0) first_mismatch <= cur_vec;
        end
        if (sweep_end) begin
          done  <= 1'b1;
          equal <= (mismatch_count == '0) && !mism;
        end else begin
          cur_vec <= cur_vec + N_IN'(1);
        end
      end
    end
  end

endmodule

// File: doc/lut_sweep_checker.md
# lut_sweep_checker

Parametrised, clocked successor to the team's combinational truth-table exercises. It holds two N-input Boolean functions as programmable truth tables (LUTs), sweeps every input vector with an internal counter, and compares the two outputs cycle by cycle. It reports equivalence, mismatch count and first failing vector. It sits beside the gate-level exercise modules as a reusable self-checking sweep engine and replaces the hand-written 16-line stimulus lists.

## Interface
Parameters:
- `N_IN`, default 4: number of function inputs; sweep length is 2^N_IN; legal range 1..8.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a sweep; sampled only in IDLE or DONE.
- `stop_first`  in  1  mode, captured at start: 0 = full sweep, 1 = stop at first mismatch.
- `lut_a`  in  2^N_IN  truth table of function A; bit i = A(vector i); captured at start.
- `lut_b`  in  2^N_IN  truth table of function B; same encoding.
- `busy`  out  1  sweep in progress.
- `done`  out  1  result valid; held until the next accepted start or reset.
- `equal`  out  1  1 when done and no mismatch found.
- `mismatch_count`  out  N_IN+1  number of differing vectors; max 2^N_IN.
- `first_mismatch`  out  N_IN  lowest differing vector index; 0 when equal.
- `cur_vec`  out  N_IN  vector being evaluated this cycle, for monitoring.
- `s_a`, `s_b`  out  1 each  A(cur_vec) and B(cur_vec), combinational from captured LUTs.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE/DONE with `start`=1 at an edge: capture `lut_a`, `lut_b` and `stop_first`; clear `cur_vec`, `mismatch_count`, `first_mismatch`, `done` and `equal`; go to SWEEP.
- SWEEP, each edge, when s_a != s_b: increment `mismatch_count`; on the first mismatch, load `first_mismatch` with `cur_vec`.
- Leaving SWEEP goes to DONE when either condition holds:
  - `cur_vec` = 2^N_IN−1.
  - `stop_first`=1 and a mismatch is found this cycle.
- If neither holds, `cur_vec` increments.
- On entry to DONE: `done`←1, `equal`←(final count==0).
- `start` during SWEEP is ignored. Changes on `lut_a`, `lut_b` or `stop_first` after capture have no effect.
- DONE with no `start`: all outputs hold.
- `mismatch_count` never wraps; its width covers 2^N_IN.
- Reset (`rst_n`=0 at an edge, any state, including mid-sweep):
  - State→IDLE.
  - `busy`, `done`, `equal`, `mismatch_count`, `first_mismatch`, `cur_vec` → 0.
  - Captured LUTs → 0, so `s_a`=`s_b`=0.

## Timing
- `busy` = (state==SWEEP), registered.
- Full sweep: `start` sampled at edge E0. `busy` is high for 2^N_IN cycles, edges E0..E(2^N_IN). `done` rises at edge E(2^N_IN) in the same edge that `busy` falls.
- Stop-first with first mismatch at vector k: `done` rises at edge E(k+1).
- Throughput: one vector per clock, no bubbles.
- Back-to-back: `start` high at the edge that enters DONE is not accepted. It is accepted from the first cycle with `done`=1.
- `s_a`, `s_b` and `cur_vec` are valid throughout SWEEP and hold their last values in DONE.

## Structure
- Shared package/header `lut_sweep_pkg`: state encodings S_IDLE=2'd0, S_SWEEP=2'd1, S_DONE=2'd2; macro for sweep length 2^N_IN.
- Sub-module `lut_cell`: parametrised (N_IN) LUT read of an indexed bit, instantiated twice, for A and B.
- Top module holds the FSM, counter and result registers.

## Test plan
All scenarios use N_IN=4 unless stated.
1. `lut_a`=`lut_b`=16'h6996, full mode, pulse `start` → `busy` high for 16 cycles, then `done`=1, `equal`=1, `mismatch_count`=0, `first_mismatch`=0.
2. `lut_a`=16'h6996, `lut_b`=16'hE997 → `mismatch_count`=2, `first_mismatch`=0, `equal`=0, `done` after 16 busy cycles.
3. `stop_first`=1, `lut_a`=16'h0000, `lut_b`=16'h0020 → `busy` for 6 cycles, `done`=1, `first_mismatch`=5, `mismatch_count`=1.
4. During sweep of scenario 1: toggle `start` and flip `lut_b` to 16'hFFFF at cycle 4 → no restart; results identical to scenario 1.
5. `rst_n`=0 at sweep cycle 8 → next edge: all outputs 0, IDLE. Then `start` with scenario 2 inputs → full 16-cycle sweep, same results as scenario 2.
6. N_IN=2 instance, `lut_a`=4'b1000, `lut_b`=4'b0111 → `busy` for 4 cycles, `mismatch_count`=4, `first_mismatch`=0, `equal`=0.
